// File: rtl/screen_triangle_assembler_pkg.sv
// Shared graphics package: fixed-point unit constant, assembler FSM state encoding
// and the registered per-vertex slot layout.
package screen_triangle_assembler_pkg;

  localparam int FracBitsDefault = 14;
  localparam int ONE             = 1 << FracBitsDefault;

  // Slot fields are sized generously so any reasonable parameterisation fits;
  // the top truncates to the configured output widths.
  localparam int SlotXW = 16;
  localparam int SlotYW = 16;
  localparam int SlotZW = 32;

  typedef enum logic [1:0] {
    StCollect,
    StEval,
    StHold
  } state_e;

  typedef struct packed {
    logic [SlotXW-1:0]        px;
    logic [SlotYW-1:0]        py;
    logic signed [SlotZW-1:0] pz;
    logic                     on_screen;
  } slot_t;

  // Fixed-point unit for an arbitrary fractional width.
  function automatic int one_of(int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/viewport_to_pixel.sv
// Combinational viewport-to-pixel conversion for one vertex.
//   x_i         : signed normalized x, ONE = 2^FRAC_BITS
//   y_i         : signed normalized y (screen row 0 is y = +ONE)
//   px_o, py_o  : pixel coordinates, clamped to the screen
//   on_screen_o : -ONE <= x < ONE and -ONE < y <= ONE
module viewport_to_pixel
  import screen_triangle_assembler_pkg::*;
#(
  parameter int FRAC_BITS  = 14,
  parameter int XW         = 18,
  parameter int YW         = 20,
  parameter int HRES       = 320,
  parameter int VRES       = 180,
  parameter int HRES_WIDTH = 9,
  parameter int VRES_WIDTH = 8
) (
  input  logic signed [XW-1:0]   x_i,
  input  logic signed [YW-1:0]   y_i,
  output logic [HRES_WIDTH-1:0]  px_o,
  output logic [VRES_WIDTH-1:0]  py_o,
  output logic                   on_screen_o
);

  // One extra bit for the offset add, one for the sign of the resolution operand.
  localparam int XPW = XW + 2 + HRES_WIDTH;
  localparam int YPW = YW + 2 + VRES_WIDTH;
  localparam int One = one_of(FRAC_BITS);

  logic signed [XPW-1:0] x_off, x_scaled;
  logic signed [YPW-1:0] y_off, y_scaled;
  logic                  on_x, on_y;

  always_comb begin
    x_off    = XPW'(x_i) + XPW'(One);
    y_off    = YPW'(One) - YPW'(y_i);
    // Arithmetic shift of a signed value is floor division by 2^(FRAC_BITS+1).
    x_scaled = (x_off * XPW'(HRES)) >>> (FRAC_BITS + 1);
    y_scaled = (y_off * YPW'(VRES)) >>> (FRAC_BITS + 1);

    // Offset coordinates lie in [0, 2*ONE) exactly when the vertex is on-screen.
    on_x = (x_off >= 0) && (x_off < XPW'(2 * One));
    on_y = (y_off >= 0) && (y_off < YPW'(2 * One));
    on_screen_o = on_x && on_y;

    if (x_scaled < 0) begin
      px_o = '0;
    end else if (x_scaled > XPW'(HRES - 1)) begin
      px_o = HRES_WIDTH'(HRES - 1);
    end else begin
      px_o = x_scaled[HRES_WIDTH-1:0];
    end

    if (y_scaled < 0) begin
      py_o = '0;
    end else if (y_scaled > YPW'(VRES - 1)) begin
      py_o = VRES_WIDTH'(VRES - 1);
    end else begin
      py_o = y_scaled[VRES_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/screen_triangle_assembler.sv
// Screen triangle assembler: converts incoming viewport vertices to pixel space,
// groups them three per triangle, culls triangles behind the camera or fully
// off-screen, and presents surviving triangles with a valid/ready handshake.
//   clk_in, rst_n_in          : clock, asynchronous active-low reset
//   valid_in / ready_out      : vertex input handshake
//   viewport_x/y_position     : signed normalized vertex position
//   z_depth                   : signed camera-space depth
//   valid_out / ready_in      : triangle output handshake
//   px, py, pz                : triangle vertex data, valid while valid_out
//   cull_count                : wrapping count of culled triangles
module screen_triangle_assembler
  import screen_triangle_assembler_pkg::*;
#(
  parameter int FRAC_BITS                 = 14,
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int Z_WIDTH                   = 19,
  parameter int HRES                      = 320,
  parameter int VRES                      = 180,
  parameter int HRES_WIDTH                = 9,
  parameter int VRES_WIDTH                = 8
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n_in,
  input  logic                                        valid_in,
  output logic                                        ready_out,
  input  logic signed [VIEWPORT_H_POSITION_WIDTH-1:0] viewport_x_position,
  input  logic signed [VIEWPORT_W_POSITION_WIDTH-1:0] viewport_y_position,
  input  logic signed [Z_WIDTH-1:0]                   z_depth,
  input  logic                                        ready_in,
  output logic                                        valid_out,
  output logic [2:0][HRES_WIDTH-1:0]                  px,
  output logic [2:0][VRES_WIDTH-1:0]                  py,
  output logic [2:0][Z_WIDTH-1:0]                     pz,
  output logic [15:0]                                 cull_count
);

  state_e          state_q, state_d;
  logic [1:0]      count_q, count_d;
  slot_t [2:0]     slots_q;
  logic [15:0]     cull_q;

  logic [HRES_WIDTH-1:0] conv_px;
  logic [VRES_WIDTH-1:0] conv_py;
  logic                  conv_on;
  logic                  accept;
  logic                  any_behind, any_on, cull;

  viewport_to_pixel #(
    .FRAC_BITS  (FRAC_BITS),
    .XW         (VIEWPORT_H_POSITION_WIDTH),
    .YW         (VIEWPORT_W_POSITION_WIDTH),
    .HRES       (HRES),
    .VRES       (VRES),
    .HRES_WIDTH (HRES_WIDTH),
    .VRES_WIDTH (VRES_WIDTH)
  ) u_conv (
    .x_i         (viewport_x_position),
    .y_i         (viewport_y_position),
    .px_o        (conv_px),
    .py_o        (conv_py),
    .on_screen_o (conv_on)
  );

  assign accept = valid_in && ready_out;

  always_comb begin
    any_behind = 1'b0;
    any_on     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ($signed(slots_q[i].pz) <= 0) any_behind = 1'b1;
      if (slots_q[i].on_screen)        any_on     = 1'b1;
    end
    cull = any_behind || !any_on;
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StCollect;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (count_q == 2'd2) begin
            count_d = 2'd0;
            state_d = StEval;
          end else begin
            count_d = count_q + 2'd1;
          end
        end
      end
      StEval:  state_d = cull ? StCollect : StHold;
      StHold:  if (ready_in) state_d = StCollect;
      default: state_d = StCollect;
    endcase
  end

  // Outputs
  always_comb begin
    ready_out = 1'b0;
    valid_out = 1'b0;
    unique case (state_q)
      StCollect: ready_out = 1'b1;
      StHold:    valid_out = 1'b1;
      default:   ;
    endcase
  end

  // Vertex slots only change on accept edges, so outputs are stable in HOLD.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slots_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept && (count_q == 2'(i))) begin
          slots_q[i].px        <= SlotXW'(conv_px);
          slots_q[i].py        <= SlotYW'(conv_py);
          slots_q[i].pz        <= SlotZW'(z_depth);
          slots_q[i].on_screen <= conv_on;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cull_q <= 16'd0;
    end else if ((state_q == StEval) && cull) begin
      cull_q <= cull_q + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      px[i] = slots_q[i].px[HRES_WIDTH-1:0];
      py[i] = slots_q[i].py[VRES_WIDTH-1:0];
      pz[i] = slots_q[i].pz[Z_WIDTH-1:0];
    end
  end

  assign cull_count = cull_q;

  // Upper slot bits beyond the configured widths are intentionally dropped.
  logic unused_slots;
  assign unused_slots = ^slots_q;

endmodule

// File: tb/tb_screen_triangle_assembler.sv
module tb_screen_triangle_assembler;

  localparam int ONE  = 16384;
  localparam int HRES = 320;
  localparam int VRES = 180;

  logic                    clk_in = 1'b0;
  logic                    rst_n_in = 1'b0;
  logic                    valid_in = 1'b0;
  logic                    ready_out;
  logic signed [17:0]      viewport_x_position = '0;
  logic signed [19:0]      viewport_y_position = '0;
  logic signed [18:0]      z_depth = '0;
  logic                    ready_in = 1'b0;
  logic                    valid_out;
  logic [2:0][8:0]         px;
  logic [2:0][7:0]         py;
  logic [2:0][18:0]        pz;
  logic [15:0]             cull_count;

  screen_triangle_assembler dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .valid_in            (valid_in),
    .ready_out           (ready_out),
    .viewport_x_position (viewport_x_position),
    .viewport_y_position (viewport_y_position),
    .z_depth             (z_depth),
    .ready_in            (ready_in),
    .valid_out           (valid_out),
    .px                  (px),
    .py                  (py),
    .pz                  (pz),
    .cull_count          (cull_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0][15:0] px;
    logic [2:0][15:0] py;
    logic [2:0][31:0] pz;
  } tri_t;

  int   total = 0;
  int   bad = 0;
  tri_t exp_q[$];
  int   bx[$], by[$], bz[$];
  int   model_cull = 0;
  tri_t cur;
  bit   have_cur = 0;
  bit   xfer_pend = 0;
  int   hold_cnt = 0;
  int   rdy_mode = 1;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the spec's formulas.
  function automatic longint floor_div(longint n, longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int ref_px(int x);
    longint v = floor_div((longint'(x) + ONE) * HRES, 2 * ONE);
    if (v < 0) return 0;
    if (v > HRES - 1) return HRES - 1;
    return int'(v);
  endfunction

  function automatic int ref_py(int y);
    longint v = floor_div((longint'(ONE) - y) * VRES, 2 * ONE);
    if (v < 0) return 0;
    if (v > VRES - 1) return VRES - 1;
    return int'(v);
  endfunction

  function automatic bit ref_on(int x, int y);
    return (x >= -ONE) && (x < ONE) && (y > -ONE) && (y <= ONE);
  endfunction

  task automatic model_accept(int x, int y, int z);
    bit   do_cull = 0;
    bit   any_on = 0;
    tri_t t;
    bx.push_back(x); by.push_back(y); bz.push_back(z);
    if (bx.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        if (bz[i] <= 0) do_cull = 1;
        if (ref_on(bx[i], by[i])) any_on = 1;
      end
      if (!any_on) do_cull = 1;
      if (do_cull) begin
        model_cull++;
      end else begin
        for (int i = 0; i < 3; i++) begin
          t.px[i] = 16'(ref_px(bx[i]));
          t.py[i] = 16'(ref_py(by[i]));
          t.pz[i] = {13'd0, 19'(bz[i])};
        end
        exp_q.push_back(t);
      end
      bx.delete(); by.delete(); bz.delete();
    end
  endtask

  task automatic send_vertex(int x, int y, int z);
    bit acc = 0;
    int guard = 0;
    @(negedge clk_in);
    valid_in = 1'b1;
    viewport_x_position = 18'(x);
    viewport_y_position = 20'(y);
    z_depth = 19'(z);
    while (!acc) begin
      acc = ready_out;
      @(posedge clk_in);
      if (!acc) begin
        guard++;
        if (guard > 200) begin
          chk("accept_timeout", 0, 1);
          #1 valid_in = 1'b0;
          return;
        end
        @(negedge clk_in);
      end
    end
    #1 valid_in = 1'b0;
    model_accept(x, y, z);
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_cull_count", cull_count, 0);
    chk("rst_px0", px[0], 0);
    chk("rst_pz2", pz[2], 0);
    exp_q.delete(); bx.delete(); by.delete(); bz.delete();
    model_cull = 0;
    have_cur = 0;
    xfer_pend = 0;
    repeat (2) @(negedge clk_in);
    #2 rst_n_in = 1'b1;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || have_cur) && guard < 200) begin
      @(negedge clk_in);
      guard++;
    end
    chk("drain_left", exp_q.size() + int'(have_cur), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    bit r;
    forever begin
      @(negedge clk_in);
      if (xfer_pend) begin
        chk("post_xfer_valid", valid_out, 0);
        chk("post_xfer_ready", ready_out, 1);
        xfer_pend = 0;
      end
      if (rst_n_in && valid_out) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid: got valid_out=1, want no triangle (t=%0t)", $time);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          have_cur = 1;
          hold_cnt = 0;
        end
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("px%0d", i), px[i], cur.px[i]);
          chk($sformatf("py%0d", i), py[i], cur.py[i]);
          chk($sformatf("pz%0d", i), pz[i], cur.pz[i]);
        end
        chk("hold_ready_out", ready_out, 0);
        case (rdy_mode)
          0:       r = ($urandom_range(0, 2) != 0);
          2:       r = (hold_cnt >= 5);
          default: r = 1'b1;
        endcase
        hold_cnt++;
        ready_in = r;
        if (r) begin
          have_cur = 0;
          xfer_pend = 1;
        end
      end else begin
        ready_in = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int x, y, z;
    #1;
    chk("init_valid_out", valid_out, 0);
    chk("init_ready_out", ready_out, 1);
    chk("init_cull_count", cull_count, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Reference triangle, latency and fixed expected pixel values
    rdy_mode = 1;
    send_vertex(0, 0, 100);
    send_vertex(-16384, 16384, 100);
    send_vertex(16383, -16383, 100);
    @(negedge clk_in);
    chk("eval_valid_out", valid_out, 0);
    chk("eval_ready_out", ready_out, 0);
    @(negedge clk_in);
    chk("lat_valid_out", valid_out, 1);
    chk("ref_px0", px[0], 160);
    chk("ref_px1", px[1], 0);
    chk("ref_px2", px[2], 319);
    chk("ref_py0", py[0], 90);
    chk("ref_py1", py[1], 0);
    chk("ref_py2", py[2], 179);
    wait_drain();

    // Zero depth culls
    send_vertex(0, 0, 100);
    send_vertex(100, 100, 0);
    send_vertex(200, 200, 100);
    @(negedge clk_in);
    chk("cull_eval_ready", ready_out, 0);
    @(negedge clk_in);
    chk("cull_ready_after", ready_out, 1);
    chk("cull_valid_out", valid_out, 0);
    chk("cull_count_1", cull_count, 1);

    // All off-screen culls; one off-screen vertex clamps
    repeat (3) send_vertex(20000, 0, 50);
    repeat (2) @(negedge clk_in);
    chk("cull_count_2", cull_count, 2);
    send_vertex(0, 0, 10);
    send_vertex(20000, 0, 10);
    send_vertex(-100, 50, 10);
    repeat (2) @(negedge clk_in);
    chk("clamp_valid", valid_out, 1);
    chk("clamp_px1", px[1], 319);
    wait_drain();

    // Five-cycle downstream stall, with valid_in offered during HOLD
    rdy_mode = 2;
    send_vertex(0, 0, 100);
    send_vertex(-16384, 16384, 100);
    send_vertex(16383, -16383, 100);
    send_vertex(1000, 1000, 77);
    wait_drain();
    rdy_mode = 1;
    send_vertex(-1000, 2000, 33);
    send_vertex(5000, -7000, 44);
    repeat (3) @(negedge clk_in);
    wait_drain();

    // Reset mid-triangle discards partial data
    send_vertex(123, 456, 9);
    send_vertex(-789, 12, 9);
    pulse_reset();
    send_vertex(0, 0, 100);
    send_vertex(-16384, 16384, 100);
    send_vertex(16383, -16383, 100);
    repeat (2) @(negedge clk_in);
    chk("post_rst_valid", valid_out, 1);
    chk("post_rst_px0", px[0], 160);
    chk("post_rst_py2", py[2], 179);
    wait_drain();

    // Randomised traffic
    rdy_mode = 0;
    for (int n = 0; n < 240; n++) begin
      if ($urandom_range(0, 9) < 8) x = int'($urandom_range(0, 2 * ONE - 1)) - ONE;
      else x = int'($urandom_range(0, (1 << 18) - 1)) - (1 << 17);
      if ($urandom_range(0, 9) < 8) y = int'($urandom_range(0, 2 * ONE - 1)) - ONE + 1;
      else y = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
      if ($urandom_range(0, 9) < 9) z = int'($urandom_range(1, 200000));
      else z = -int'($urandom_range(0, 500));
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      send_vertex(x, y, z);
    end
    repeat (3) @(negedge clk_in);
    rdy_mode = 1;
    wait_drain();
    chk("final_cull_count", cull_count, model_cull % 65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
